// File: rtl/xt_keyboard_irq_sequencer.sv
// Buffers PS/2 set-1 bytes and hands them to the XT/Tandy side one at a time as IRQ1 pulses with a guaranteed low gap.
// Optional: define OVERRUN_CODE_EN to insert an 8'hFF overrun code into the stream after a dropped byte.
module xt_keyboard_irq_sequencer #(
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    input  logic                     clear_keycode,
    output logic [7:0]               scancode,
    output logic                     keybord_irq,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_GAP} state_t;

    state_t        state, state_nxt;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [GW-1:0] gap_cnt;
    logic          clr_q, clr_rise;
    logic          empty, full, space;
    logic          pop, gap_load, wr_en;
    logic [7:0]    wr_data;

    assign clr_rise = clear_keycode & ~clr_q;
    assign empty    = (fifo_count == '0);
    assign full     = (fifo_count == (AW+1)'(DEPTH));
    // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
    assign space    = ~full | pop;

`ifdef OVERRUN_CODE_EN
    logic pending_overrun;

    assign wr_en   = pending_overrun ? space : (rx_valid & space);
    assign wr_data = pending_overrun ? 8'hFF : rx_data;

    always_ff @(posedge clock) begin
        if (reset)
            pending_overrun <= 1'b0;
        else if (pending_overrun & space)
            pending_overrun <= 1'b0;
        else if (rx_valid & ~space)
            pending_overrun <= 1'b1;
    end
`else
    assign wr_en   = rx_valid & space;
    assign wr_data = rx_data;
`endif

    // FIFO storage carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (rx_valid & ~space)
                overflow <= 1'b1;
        end
    end

    // State register; scancode and IRQ are registered so they move on the same edge as the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            gap_cnt     <= '0;
            clr_q       <= 1'b0;
            scancode    <= 8'h00;
            keybord_irq <= 1'b0;
        end else begin
            state       <= state_nxt;
            clr_q       <= clear_keycode;
            keybord_irq <= (state_nxt == S_ASSERT);
            if (pop)
                scancode <= mem[rd_ptr];
            if (gap_load)
                gap_cnt <= GW'(GAP_CYCLES - 1);
            else if (state == S_GAP && gap_cnt != '0)
                gap_cnt <= gap_cnt - GW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (!empty)          state_nxt = S_ASSERT;
            S_ASSERT: if (clr_rise)        state_nxt = S_GAP;
            S_GAP:    if (gap_cnt == '0)   state_nxt = S_IDLE;
            default:                       state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        pop      = (state == S_IDLE) && !empty;
        gap_load = (state == S_ASSERT) && clr_rise;
    end
endmodule

// File: tb/tb_xt_keyboard_irq_sequencer.sv
// Directed bench for xt_keyboard_irq_sequencer (DEPTH=16, GAP_CYCLES=4, default build).
module tb_xt_keyboard_irq_sequencer;
    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       clear_keycode;
    logic [7:0] scancode;
    logic       keybord_irq;
    logic [4:0] fifo_count;
    logic       overflow;

    int vectors    = 0;
    int miscompares = 0;
    int lowcnt;

    xt_keyboard_irq_sequencer #(.DEPTH(16), .GAP_CYCLES(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .clear_keycode (clear_keycode),
        .scancode      (scancode),
        .keybord_irq   (keybord_irq),
        .fifo_count    (fifo_count),
        .overflow      (overflow)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ack();
        clear_keycode = 1'b1;
        tick();
        clear_keycode = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; clear_keycode = 1'b0;
        tick(); tick();
        chk("rst_irq", 32'(keybord_irq), 0);
        chk("rst_scancode", 32'(scancode), 32'h00);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_overflow", 32'(overflow), 0);
        reset = 1'b0;

        // Single byte: visible two cycles after the strobe
        rx_data = 8'h1E; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
        chk("single_count1", 32'(fifo_count), 1);
        chk("single_irq_early", 32'(keybord_irq), 0);
        tick();
        chk("single_irq", 32'(keybord_irq), 1);
        chk("single_scancode", 32'(scancode), 32'h1E);
        chk("single_count0", 32'(fifo_count), 0);
        repeat (8) tick();
        chk("single_hold_irq", 32'(keybord_irq), 1);
        chk("single_hold_code", 32'(scancode), 32'h1E);
        ack();
        chk("single_irq_fall", 32'(keybord_irq), 0);
        repeat (6) tick();
        chk("single_stay_low", 32'(keybord_irq), 0);

        // E0 48 back-to-back: two pulses separated by GAP_CYCLES+1 low cycles
        rx_data = 8'hE0; rx_valid = 1'b1; tick();
        rx_data = 8'h48; tick(); rx_valid = 1'b0;
        chk("e0_irq", 32'(keybord_irq), 1);
        chk("e0_code", 32'(scancode), 32'hE0);
        chk("e0_count", 32'(fifo_count), 1);
        tick();
        chk("e0_code_stable", 32'(scancode), 32'hE0);
        ack();
        chk("e0_fall", 32'(keybord_irq), 0);
        chk("e0_code_in_gap", 32'(scancode), 32'hE0);
        lowcnt = 1;
        for (int i = 0; i < 20 && !keybord_irq; i++) begin
            tick();
            if (!keybord_irq) lowcnt++;
        end
        chk("e0_gap_len", 32'(lowcnt), 5);
        chk("e0_second_irq", 32'(keybord_irq), 1);
        chk("e0_second_code", 32'(scancode), 32'h48);
        chk("e0_drained", 32'(fifo_count), 0);
        ack();
        repeat (6) tick();

        // No ack: first byte held, clear already high on entry does not advance
        rx_data = 8'h10; rx_valid = 1'b1; tick();
        rx_data = 8'h11; tick();
        rx_data = 8'h12; tick(); rx_valid = 1'b0;
        chk("noack_irq", 32'(keybord_irq), 1);
        chk("noack_code", 32'(scancode), 32'h10);
        chk("noack_count", 32'(fifo_count), 2);
        repeat (5) tick();
        chk("noack_still_code", 32'(scancode), 32'h10);
        clear_keycode = 1'b1; tick();
        chk("noack_fall", 32'(keybord_irq), 0);
        repeat (5) tick();
        chk("hi_entry_irq", 32'(keybord_irq), 1);
        chk("hi_entry_code", 32'(scancode), 32'h11);
        chk("hi_entry_count", 32'(fifo_count), 1);
        repeat (5) tick();
        chk("hi_held_irq", 32'(keybord_irq), 1);
        chk("hi_held_code", 32'(scancode), 32'h11);
        clear_keycode = 1'b0; tick();
        clear_keycode = 1'b1; tick();
        chk("hi_rise_fall", 32'(keybord_irq), 0);
        clear_keycode = 1'b0;
        repeat (5) tick();
        chk("noack_third_code", 32'(scancode), 32'h12);
        ack();
        repeat (6) tick();
        chk("noack_empty", 32'(fifo_count), 0);

        // Fill to exactly full: 17 bytes, first one is out on scancode
        rx_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            rx_data = 8'(8'h20 + i);
            tick();
        end
        rx_valid = 1'b0;
        chk("full_count", 32'(fifo_count), 16);
        chk("full_overflow", 32'(overflow), 0);
        chk("full_code", 32'(scancode), 32'h20);

        // Write in the same cycle as the IDLE pop from a full FIFO
        ack();
        repeat (4) tick();
        chk("sim_idle_low", 32'(keybord_irq), 0);
        rx_data = 8'h55; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
        chk("sim_count", 32'(fifo_count), 16);
        chk("sim_overflow", 32'(overflow), 0);
        chk("sim_code", 32'(scancode), 32'h21);
        chk("sim_irq", 32'(keybord_irq), 1);

        // One more byte while full and holding: dropped
        rx_data = 8'h66; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
        chk("ovf_count", 32'(fifo_count), 16);
        chk("ovf_flag", 32'(overflow), 1);
        tick();
        chk("ovf_sticky", 32'(overflow), 1);

        // Reset mid-ASSERT
        reset = 1'b1; tick(); reset = 1'b0;
        chk("midrst_irq", 32'(keybord_irq), 0);
        chk("midrst_code", 32'(scancode), 32'h00);
        chk("midrst_count", 32'(fifo_count), 0);
        chk("midrst_overflow", 32'(overflow), 0);
        repeat (3) tick();
        chk("midrst_quiet", 32'(keybord_irq), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
